// File: rtl/cache_data_structs.sv
// Shared types and address-field constants for the direct-mapped cache.
// No ports: imported by cache_line_store and cache_controller.
package cache_data_structs;

    localparam int NUM_LINES  = 32;
    localparam int LINE_BITS  = 64;
    localparam int TAG_BITS   = 24;
    localparam int INDEX_BITS = 5;

    localparam int TAG_MSB   = 31;
    localparam int TAG_LSB   = 8;
    localparam int INDEX_MSB = 7;
    localparam int INDEX_LSB = 3;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_BITS-1:0] tag;
    } tag_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_res_type;

    typedef struct packed {
        logic [31:0]          addr;
        logic [LINE_BITS-1:0] data;
        logic                 rw;
        logic                 valid;
    } mem_req_type;

    typedef struct packed {
        logic [LINE_BITS-1:0] data;
        logic                 ready;
    } mem_res_type;

endpackage

// File: rtl/cache_line_store.sv
// Tag and data arrays for the cache: combinational read, clocked write.
// Ports:
//   clk, n_rst             clock, synchronous active-high reset (clears tag entries)
//   index                  line selected for both read and write
//   tag_we / tag_wdata     tag entry write
//   data_we / data_wdata   line data write
//   tag_rdata / data_rdata combinational read of the selected line
module cache_line_store
    import cache_data_structs::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [INDEX_BITS-1:0] index,
    input  logic                  tag_we,
    input  tag_type               tag_wdata,
    input  logic                  data_we,
    input  logic [LINE_BITS-1:0]  data_wdata,
    output tag_type               tag_rdata,
    output logic [LINE_BITS-1:0]  data_rdata
);

    tag_type              tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];

    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (tag_we) begin
            tag_mem[index] <= tag_wdata;
        end
    end

    // Data is not reset; a cleared valid bit makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[index] <= data_wdata;
        end
    end

    assign tag_rdata  = tag_mem[index];
    assign data_rdata = data_mem[index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   clk, n_rst  clock, synchronous active-high reset
//   cpu_req     {addr, data, rw, valid} from the CPU (rw=1 write), held until ready
//   cpu_res     {data, ready}; ready pulses for one cycle on a hit in COMPARE_TAG
//   mem_req     {addr, data, rw, valid} to memory, registered and held until mem_res.ready
//   mem_res     {data, ready} from memory
module cache_controller
    import cache_data_structs::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  cpu_req_type cpu_req,
    output cpu_res_type cpu_res,
    output mem_req_type mem_req,
    input  mem_res_type mem_res
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] COMPARE_TAG = 2'd1;
    localparam logic [1:0] ALLOCATE    = 2'd2;
    localparam logic [1:0] WRITE_BACK  = 2'd3;

    logic [1:0]  state_q, state_d;
    cpu_req_type req_q, req_d;
    mem_req_type mem_req_q, mem_req_d;

    logic                  tag_we;
    tag_type               tag_wdata;
    logic                  data_we;
    logic [LINE_BITS-1:0]  data_wdata;
    tag_type               tag_rdata;
    logic [LINE_BITS-1:0]  data_rdata;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  word_sel;
    logic                  hit;
    mem_req_type           refill_req;
    mem_req_type           wb_req;

    assign index    = req_q.addr[INDEX_MSB:INDEX_LSB];
    assign req_tag  = req_q.addr[TAG_MSB:TAG_LSB];
    assign word_sel = req_q.addr[2];
    assign hit      = tag_rdata.valid && (tag_rdata.tag == req_tag);

    assign refill_req = '{addr: {req_q.addr[31:3], 3'b000}, data: '0, rw: 1'b0, valid: 1'b1};
    // Victim address is rebuilt from the old tag before this cycle overwrites it.
    assign wb_req     = '{addr: {tag_rdata.tag, index, 3'b000}, data: data_rdata,
                          rw: 1'b1, valid: 1'b1};

    cache_line_store u_store (
        .clk        (clk),
        .n_rst      (n_rst),
        .index      (index),
        .tag_we     (tag_we),
        .tag_wdata  (tag_wdata),
        .data_we    (data_we),
        .data_wdata (data_wdata),
        .tag_rdata  (tag_rdata),
        .data_rdata (data_rdata)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        mem_req_d  = mem_req_q;
        tag_we     = 1'b0;
        tag_wdata  = '0;
        data_we    = 1'b0;
        data_wdata = data_rdata;
        cpu_res    = '0;

        case (state_q)
            IDLE: begin
                mem_req_d = '0;
                if (cpu_req.valid) begin
                    req_d   = cpu_req;
                    state_d = COMPARE_TAG;
                end
            end
            COMPARE_TAG: begin
                if (hit) begin
                    cpu_res.ready = 1'b1;
                    mem_req_d     = '0;
                    state_d       = IDLE;
                    if (req_q.rw) begin
                        tag_we    = 1'b1;
                        tag_wdata = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                        data_we   = 1'b1;
                        if (word_sel) data_wdata[63:32] = req_q.data;
                        else          data_wdata[31:0]  = req_q.data;
                    end else begin
                        cpu_res.data = word_sel ? data_rdata[63:32] : data_rdata[31:0];
                    end
                end else begin
                    // Claim the line now; the refill makes the retry in COMPARE_TAG hit.
                    tag_we    = 1'b1;
                    tag_wdata = '{valid: 1'b1, dirty: req_q.rw, tag: req_tag};
                    if (tag_rdata.valid && tag_rdata.dirty) begin
                        mem_req_d = wb_req;
                        state_d   = WRITE_BACK;
                    end else begin
                        mem_req_d = refill_req;
                        state_d   = ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                if (mem_res.ready) begin
                    mem_req_d = refill_req;
                    state_d   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_res.ready) begin
                    data_we    = 1'b1;
                    data_wdata = mem_res.data;
                    mem_req_d  = '0;
                    state_d    = COMPARE_TAG;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            mem_req_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign mem_req = mem_req_q;

    logic unused_req_bits;
    assign unused_req_bits = ^{req_q.addr[1:0], req_q.valid};

endmodule

// File: tb/tb_cache_controller.sv
// Directed test of cache_controller: cold miss, hits, write hit, dirty eviction,
// write-allocate merge, and reset during a refill.
module tb_cache_controller;
    import cache_data_structs::*;

    logic        clk;
    logic        n_rst;
    cpu_req_type cpu_req;
    cpu_res_type cpu_res;
    mem_req_type mem_req;
    mem_res_type mem_res;

    int total;
    int bad;

    cache_controller dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .cpu_req (cpu_req),
        .cpu_res (cpu_res),
        .mem_req (mem_req),
        .mem_res (mem_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic mem_req_type mreq(input logic [31:0] a, input logic [63:0] d,
                                         input logic rw);
        mreq = '{addr: a, data: d, rw: rw, valid: 1'b1};
    endfunction

    function automatic cpu_req_type creq(input logic [31:0] a, input logic [31:0] d,
                                         input logic rw);
        creq = '{addr: a, data: d, rw: rw, valid: 1'b1};
    endfunction

    function automatic cpu_res_type cres(input logic [31:0] d);
        cres = '{data: d, ready: 1'b1};
    endfunction

    // One hit access: ready must be up the cycle after valid is sampled in IDLE.
    task automatic hit_access(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic rw, input logic [31:0] exp_data);
        cpu_req = creq(a, d, rw);
        tick();
        check({tag, "_res"}, cpu_res, cres(exp_data));
        check({tag, "_memv"}, mem_req.valid, 1'b0);
        cpu_req = '0;
        tick();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        n_rst   = 1'b1;
        cpu_req = '0;
        mem_res = '0;
        repeat (5) tick();
        check("rst_cpu_res", cpu_res, 33'd0);
        check("rst_mem_req", mem_req, 98'd0);
        n_rst = 1'b0;

        // Cold read of 0xF8: index 31, tag 0, addr[2]=0 selects the low word.
        cpu_req = creq(32'h0000_00F8, 32'h0, 1'b0);
        tick();
        check("cold_ct_noready", cpu_res.ready, 1'b0);
        tick();
        check("cold_refill_req", mem_req, mreq(32'h0000_00F8, 64'h0, 1'b0));
        tick();
        check("cold_alloc_hold", mem_req, mreq(32'h0000_00F8, 64'h0, 1'b0));
        mem_res = '{data: 64'h1111_2222_3333_4444, ready: 1'b1};
        tick();
        mem_res = '0;
        check("cold_res", cpu_res, cres(32'h3333_4444));
        check("cold_memv_drop", mem_req.valid, 1'b0);
        cpu_req = '0;
        tick();
        check("idle_res_zero", cpu_res, 33'd0);

        hit_access("hit_fc", 32'h0000_00FC, 32'h0, 1'b0, 32'h1111_2222);
        hit_access("hit_f8", 32'h0000_00F8, 32'h0, 1'b0, 32'h3333_4444);
        hit_access("whit_f8", 32'h0000_00F8, 32'hDEAD_BEEF, 1'b1, 32'h0);
        hit_access("rd_after_w", 32'h0000_00F8, 32'h0, 1'b0, 32'hDEAD_BEEF);
        hit_access("rd_fc_keep", 32'h0000_00FC, 32'h0, 1'b0, 32'h1111_2222);

        // Same index, tag 1: the dirty line must be written back first.
        cpu_req = creq(32'h0000_01F8, 32'h0, 1'b0);
        tick();
        tick();
        check("wb_req", mem_req, mreq(32'h0000_00F8, 64'h1111_2222_DEAD_BEEF, 1'b1));
        check("wb_noready", cpu_res.ready, 1'b0);
        tick();
        check("wb_hold", mem_req, mreq(32'h0000_00F8, 64'h1111_2222_DEAD_BEEF, 1'b1));
        mem_res = '{data: 64'h0, ready: 1'b1};
        tick();
        mem_res = '0;
        check("wb_then_refill", mem_req, mreq(32'h0000_01F8, 64'h0, 1'b0));
        mem_res = '{data: 64'h5555_6666_7777_8888, ready: 1'b1};
        tick();
        mem_res = '0;
        check("dirty_miss_res", cpu_res, cres(32'h7777_8888));
        cpu_req = '0;
        tick();

        // Write miss to 0x200 (index 0, tag 2): refill, then merge the low word.
        cpu_req = creq(32'h0000_0200, 32'h1234_5678, 1'b1);
        tick();
        tick();
        check("wmiss_refill", mem_req, mreq(32'h0000_0200, 64'h0, 1'b0));
        mem_res = '{data: 64'hAAAA_BBBB_CCCC_DDDD, ready: 1'b1};
        tick();
        mem_res = '0;
        check("wmiss_res", cpu_res, cres(32'h0));
        cpu_req = '0;
        tick();

        // Read 0x300 (index 0, tag 3) evicts the merged, dirty line.
        cpu_req = creq(32'h0000_0300, 32'h0, 1'b0);
        tick();
        tick();
        check("merge_wb", mem_req, mreq(32'h0000_0200, 64'hAAAA_BBBB_1234_5678, 1'b1));
        mem_res = '{data: 64'h0, ready: 1'b1};
        tick();
        mem_res = '0;
        check("rst_alloc_req", mem_req, mreq(32'h0000_0300, 64'h0, 1'b0));

        // Reset while in ALLOCATE abandons the refill.
        n_rst = 1'b1;
        tick();
        check("rst_mid_memv", mem_req.valid, 1'b0);
        check("rst_mid_res", cpu_res, 33'd0);
        n_rst = 1'b0;
        tick();
        check("reread_miss", cpu_res.ready, 1'b0);
        tick();
        check("reread_clean", mem_req, mreq(32'h0000_0300, 64'h0, 1'b0));
        mem_res = '{data: 64'h9999_AAAA_BBBB_CCCC, ready: 1'b1};
        tick();
        mem_res = '0;
        check("reread_res", cpu_res, cres(32'hBBBB_CCCC));
        cpu_req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
